// File: rtl/aes_key_schedule_server.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_server
//
// Serves AES-128 round-key words (w[0]..w[43]) to the serial AES core. The
// 128-bit cipher key is expanded on the fly. Only the current round window
// (four words) and the original key are stored.
//
// Word order and wrap:
//   - A next pulse advances to the following word.
//   - The index wraps from 43 back to 0. A consumer can therefore reach any
//     round by scanning forward. The decrypt path uses this wrap-scan to get
//     the round keys in reverse order.
//
// Parameter:
//   SBOX_SERIAL  0: four parallel S-boxes. A new round is produced in the
//                   same edge that advances from w[4r-1].
//                1: one shared S-box. A new round takes 4 extra cycles, and
//                   ready is low during those cycles.
//
// Ports:
//   clk        in   1    clock, posedge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    load key and restart the schedule at w[0]
//   key        in   128  cipher key; key[127:96] is w[0]
//   next       in   1    advance one word; honoured only while ready=1
//   round_key  out  32   current schedule word w[word_addr]
//   word_addr  out  6    index of round_key, 0..43
//   ready      out  1    round_key/word_addr are valid
// ---------------------------------------------------------------------------
module aes_key_schedule_server #(
  parameter int SBOX_SERIAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         next,
  output logic [31:0]  round_key,
  output logic [5:0]   word_addr,
  output logic         ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] CALC  = 2'd3;

  localparam logic [5:0] LAST_ADDR = 6'd43;

  logic [1:0]   state;
  logic [127:0] key_reg;
  logic [31:0]  w0, w1, w2, w3;
  logic [7:0]   rcon;
  logic [1:0]   calc_cnt;
  logic [23:0]  temp;

  logic [31:0] rot_w3;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic [31:0] sub_word;
  logic [31:0] t_word;
  logic [31:0] nw0, nw1, nw2, nw3;
  logic [31:0] win_sel;

  // Multiply by x in GF(2^8). This is also the rcon update (0x80 -> 0x1B).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // The S-box is computed rather than tabulated:
  //   1. Take the inverse as x^254. This maps 0 to 0, as the S-box requires.
  //   2. Apply the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round datapath.
  //   - The serial variant feeds one byte of RotWord(W3) per CALC cycle,
  //     MSB first.
  //   - The last byte comes straight from the shared S-box. The whole round
  //     commits on the fourth CALC edge.
  //   - The in-round word select points at window slot (a+1)%4.
  always_comb begin
    rot_w3  = {w3[23:0], w3[31:24]};
    sbox_in = 8'h00;
    case (calc_cnt)
      2'd0:    sbox_in = rot_w3[31:24];
      2'd1:    sbox_in = rot_w3[23:16];
      2'd2:    sbox_in = rot_w3[15:8];
      default: sbox_in = rot_w3[7:0];
    endcase
    sbox_out = sbox(sbox_in);
    if (SBOX_SERIAL != 0) begin
      sub_word = {temp, sbox_out};
    end else begin
      sub_word = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                  sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    end
    t_word = sub_word ^ {rcon, 24'h000000};
    nw0    = w0 ^ t_word;
    nw1    = w1 ^ nw0;
    nw2    = w2 ^ nw1;
    nw3    = w3 ^ nw2;
    case (word_addr[1:0] + 2'd1)
      2'd0:    win_sel = w0;
      2'd1:    win_sel = w1;
      2'd2:    win_sel = w2;
      default: win_sel = w3;
    endcase
  end

  // Control and state.
  //   - start overrides everything, including an unfinished CALC.
  //   - The wrap at index 43 is checked first, because 43 is also a
  //     round-boundary index (43 % 4 == 3).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      rcon      <= 8'h01;
      calc_cnt  <= 2'd0;
      temp      <= '0;
      round_key <= '0;
      word_addr <= '0;
      ready     <= 1'b0;
    end else if (start) begin
      key_reg  <= key;
      w0       <= key[127:96];
      w1       <= key[95:64];
      w2       <= key[63:32];
      w3       <= key[31:0];
      rcon     <= 8'h01;
      calc_cnt <= 2'd0;
      ready    <= 1'b0;
      state    <= LOAD;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        LOAD: begin
          round_key <= key_reg[127:96];
          word_addr <= '0;
          ready     <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (next) begin
            if (word_addr == LAST_ADDR) begin
              w0        <= key_reg[127:96];
              w1        <= key_reg[95:64];
              w2        <= key_reg[63:32];
              w3        <= key_reg[31:0];
              rcon      <= 8'h01;
              word_addr <= '0;
              round_key <= key_reg[127:96];
            end else if (word_addr[1:0] != 2'd3) begin
              word_addr <= word_addr + 6'd1;
              round_key <= win_sel;
            end else if (SBOX_SERIAL != 0) begin
              calc_cnt <= 2'd0;
              ready    <= 1'b0;
              state    <= CALC;
            end else begin
              w0        <= nw0;
              w1        <= nw1;
              w2        <= nw2;
              w3        <= nw3;
              rcon      <= xtime(rcon);
              word_addr <= word_addr + 6'd1;
              round_key <= nw0;
            end
          end
        end
        CALC: begin
          if (calc_cnt == 2'd3) begin
            w0        <= nw0;
            w1        <= nw1;
            w2        <= nw2;
            w3        <= nw3;
            rcon      <= xtime(rcon);
            word_addr <= word_addr + 6'd1;
            round_key <= nw0;
            ready     <= 1'b1;
            calc_cnt  <= 2'd0;
            state     <= VALID;
          end else begin
            case (calc_cnt)
              2'd0:    temp[23:16] <= sbox_out;
              2'd1:    temp[15:8]  <= sbox_out;
              default: temp[7:0]   <= sbox_out;
            endcase
            calc_cnt <= calc_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_server.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_server
//
// Directed bench with two instances of the key schedule server:
//   dut0  SBOX_SERIAL=0 (parallel S-boxes)
//   dut1  SBOX_SERIAL=1 (single shared S-box)
//
// Expected words are FIPS-197 Appendix A.1 values for key
// 2b7e151628aed2a6abf7158809cf4f3c, plus the first round of the all-ones
// key. Inputs change on the falling edge, and outputs are read there too.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_server;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ONES_KEY = {128{1'b1}};

  typedef struct {
    int          nexts;
    logic [5:0]  addr;
    logic [31:0] word;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start0, start1;
  logic [127:0] key0, key1;
  logic         next0, next1;
  logic [31:0]  round_key0, round_key1;
  logic [5:0]   word_addr0, word_addr1;
  logic         ready0, ready1;

  int checks;
  int errors;
  vec_t vecs[12];

  aes_key_schedule_server #(.SBOX_SERIAL(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .key       (key0),
    .next      (next0),
    .round_key (round_key0),
    .word_addr (word_addr0),
    .ready     (ready0)
  );

  aes_key_schedule_server #(.SBOX_SERIAL(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .key       (key1),
    .next      (next1),
    .round_key (round_key1),
    .word_addr (word_addr1),
    .ready     (ready1)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck bench still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Holds next0 high for n rising edges. Called and returns on a falling edge.
  task automatic applyStimulus(input int n);
    if (n > 0) begin
      next0 = 1'b1;
      repeat (n) @(negedge clk);
      next0 = 1'b0;
    end
  endtask

  // Pulses start0 with key k. Returns on the falling edge after LOAD.
  task automatic startDut0(input logic [127:0] k);
    start0 = 1'b1;
    key0   = k;
    @(negedge clk);
    start0 = 1'b0;
    checkOutput("dut0 ready in LOAD", {31'd0, ready0}, 32'd0);
    @(negedge clk);
  endtask

  // Pulses start1 with key k. next1 is held high during LOAD to show it is ignored.
  task automatic startDut1(input logic [127:0] k);
    start1 = 1'b1;
    key1   = k;
    @(negedge clk);
    start1 = 1'b0;
    next1  = 1'b1;
    checkOutput("dut1 ready in LOAD", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    next1 = 1'b0;
  endtask

  // One next pulse on dut1, then wait (bounded) for ready to return.
  task automatic stepDut1();
    int n;
    next1 = 1'b1;
    @(negedge clk);
    next1 = 1'b0;
    n = 0;
    while (!ready1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ready1) checkOutput("dut1 ready timeout", {31'd0, ready1}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{0,  6'd0,  32'h2b7e1516};
    vecs[1]  = '{1,  6'd1,  32'h28aed2a6};
    vecs[2]  = '{1,  6'd2,  32'habf71588};
    vecs[3]  = '{1,  6'd3,  32'h09cf4f3c};
    vecs[4]  = '{1,  6'd4,  32'ha0fafe17};
    vecs[5]  = '{1,  6'd5,  32'h88542cb1};
    vecs[6]  = '{1,  6'd6,  32'h23a33939};
    vecs[7]  = '{1,  6'd7,  32'h2a6c7605};
    vecs[8]  = '{33, 6'd40, 32'hd014f9a8};
    vecs[9]  = '{3,  6'd43, 32'hb6630ca6};
    vecs[10] = '{1,  6'd0,  32'h2b7e1516};
    vecs[11] = '{4,  6'd4,  32'ha0fafe17};

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    key0   = '0;
    key1   = '0;
    next0  = 1'b0;
    next1  = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("dut0 reset ready", {31'd0, ready0}, 32'd0);
    checkOutput("dut0 reset addr", {26'd0, word_addr0}, 32'd0);
    checkOutput("dut0 reset key", round_key0, 32'd0);
    checkOutput("dut1 reset ready", {31'd0, ready1}, 32'd0);
    rst_n = 1'b1;

    // next in IDLE is ignored
    next0 = 1'b1;
    @(negedge clk);
    next0 = 1'b0;
    checkOutput("dut0 idle ready", {31'd0, ready0}, 32'd0);

    // Test 1 and wrap: FIPS table walk on dut0
    startDut0(FIPS_KEY);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].nexts);
      checkOutput($sformatf("vec%0d addr", i), {26'd0, word_addr0}, {26'd0, vecs[i].addr});
      checkOutput($sformatf("vec%0d word", i), round_key0, vecs[i].word);
      checkOutput($sformatf("vec%0d ready", i), {31'd0, ready0}, 32'd1);
    end

    // Test 2: next held high, one word per cycle, through the wrap
    startDut0(FIPS_KEY);
    next0 = 1'b1;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stream addr %0d", i), {26'd0, word_addr0}, i % 44);
      checkOutput($sformatf("stream ready %0d", i), {31'd0, ready0}, 32'd1);
      if (i == 4) checkOutput("stream w4", round_key0, 32'ha0fafe17);
      if (i == 44) checkOutput("stream w0 after wrap", round_key0, 32'h2b7e1516);
    end
    next0 = 1'b0;

    // Test 6: asynchronous reset at word_addr=20
    startDut0(FIPS_KEY);
    applyStimulus(20);
    checkOutput("pre-reset addr", {26'd0, word_addr0}, 32'd20);
    checkOutput("pre-reset w20", round_key0, 32'hd4d1c6f8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset ready", {31'd0, ready0}, 32'd0);
    checkOutput("async reset addr", {26'd0, word_addr0}, 32'd0);
    checkOutput("async reset key", round_key0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("post-reset next ignored ready", {31'd0, ready0}, 32'd0);
    checkOutput("post-reset next ignored addr", {26'd0, word_addr0}, 32'd0);

    // Test 3: serial S-box, next ignored in LOAD
    startDut1(FIPS_KEY);
    checkOutput("dut1 w0 addr", {26'd0, word_addr1}, 32'd0);
    checkOutput("dut1 w0", round_key1, 32'h2b7e1516);
    stepDut1();
    stepDut1();
    checkOutput("dut1 w2", round_key1, 32'habf71588);
    next1 = 1'b1;
    @(negedge clk);
    next1 = 1'b0;
    checkOutput("dut1 ready at 2->3", {31'd0, ready1}, 32'd1);
    checkOutput("dut1 addr 3", {26'd0, word_addr1}, 32'd3);
    checkOutput("dut1 w3", round_key1, 32'h09cf4f3c);

    // Round boundary: ready low for exactly 4 cycles, next held high meanwhile
    next1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("calc ready low %0d", i), {31'd0, ready1}, 32'd0);
      checkOutput($sformatf("calc addr hold %0d", i), {26'd0, word_addr1}, 32'd3);
    end
    next1 = 1'b0;
    @(negedge clk);
    checkOutput("calc done ready", {31'd0, ready1}, 32'd1);
    checkOutput("calc done addr", {26'd0, word_addr1}, 32'd4);
    checkOutput("calc done w4", round_key1, 32'ha0fafe17);
    stepDut1();
    stepDut1();
    stepDut1();
    checkOutput("dut1 w7", round_key1, 32'h2a6c7605);

    // Test 5: start in CALC cycle 2 with a new key
    next1 = 1'b1;
    @(negedge clk);
    next1 = 1'b0;
    checkOutput("dut1 enter calc", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    start1 = 1'b1;
    key1   = ONES_KEY;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("restart load ready", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    checkOutput("restart ready", {31'd0, ready1}, 32'd1);
    checkOutput("restart addr", {26'd0, word_addr1}, 32'd0);
    checkOutput("restart w0", round_key1, 32'hffffffff);
    repeat (4) stepDut1();
    checkOutput("restart addr 4", {26'd0, word_addr1}, 32'd4);
    checkOutput("restart w4", round_key1, 32'he8e9e9e9);
    stepDut1();
    checkOutput("restart w5", round_key1, 32'h17161616);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
